// File: rtl/max_layer_pkg.sv
// Shared training-datapath constants and the max_layer state type.
//
// The size macros (`N, `CHAR_NUM, `N_LEN, `CHAR_LEN) are the common
// dimensions of the training datapath. The `MAX_* macros give the 2-bit
// state encoding of the max_layer scan FSM.
//
// The package carries the FSM enum, integer mirrors of the size macros, and
// a helper function that locates one logit inside the flattened logit bus.
`ifndef CONSTS_TRAIN_VH
`define CONSTS_TRAIN_VH
`define N        2
`define CHAR_NUM 10
`define N_LEN    16
`define CHAR_LEN 4
`define MAX_IDLE 2'd0
`define MAX_SCAN 2'd1
`define MAX_DONE 2'd2
`endif

package max_layer_pkg;

    typedef enum logic [1:0] {
        MAX_ST_IDLE = `MAX_IDLE,
        MAX_ST_SCAN = `MAX_SCAN,
        MAX_ST_DONE = `MAX_DONE
    } max_state_e;

    localparam int ROWS = `N;
    localparam int COLS = `CHAR_NUM;
    localparam int VW   = `N_LEN;
    localparam int IW   = `CHAR_LEN;

    // Bit offset of element (row r, col c) in the flattened logit bus.
    function automatic int elem_lsb(input int r, input int c);
        return (r * `CHAR_NUM + c) * `N_LEN;
    endfunction

endpackage

// File: rtl/max_cmp.sv
// One-row compare/select step of the running max scan.
//
// Ports:
//   cur_max  running maximum of the row so far
//   cur_idx  column index of cur_max
//   new_val  element of the row at column col
//   col      column currently being examined
//   nxt_max  updated running maximum
//   nxt_idx  updated argmax
//
// Only a strictly greater value replaces the running maximum, so ties keep
// the lowest column index.
module max_cmp (
    input  logic [`N_LEN-1:0]    cur_max,
    input  logic [`CHAR_LEN-1:0] cur_idx,
    input  logic [`N_LEN-1:0]    new_val,
    input  logic [`CHAR_LEN-1:0] col,
    output logic [`N_LEN-1:0]    nxt_max,
    output logic [`CHAR_LEN-1:0] nxt_idx
);

    // Signed strict-greater select between running max and the new element.
    always_comb begin
        nxt_max = cur_max;
        nxt_idx = cur_idx;
        if ($signed(new_val) > $signed(cur_max)) begin
            nxt_max = new_val;
            nxt_idx = col;
        end else begin
            nxt_max = cur_max;
            nxt_idx = cur_idx;
        end
    end

endmodule

// File: rtl/max_layer.sv
// Per-row max / argmax of one batch slot of logits.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   run    level request: high starts a scan and holds the result,
//          low releases the result or aborts a scan in progress
//   d      N x CHAR_NUM signed logits, element (r,c) at (r*CHAR_NUM+c)*N_LEN
//   valid  registered result-ready flag
//   q_max  per-row maximum, row r at r*N_LEN
//   q_idx  per-row argmax, row r at r*CHAR_LEN
//
// The logits are captured when a scan starts, column 0 seeds the running
// max, and then one column per cycle is compared for all rows in parallel.
// q_max/q_idx change only when a scan completes.
module max_layer
    import max_layer_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              run,
    input  logic [`N*`CHAR_NUM*`N_LEN-1:0]    d,
    output logic                              valid,
    output logic [`N*`N_LEN-1:0]              q_max,
    output logic [`N*`CHAR_LEN-1:0]           q_idx
);

    max_state_e                         state_r;
    max_state_e                         state_nxt_s;
    logic [`CHAR_LEN:0]                 col_r;
    logic [`CHAR_LEN:0]                 col_sel_s;
    logic [`N*`CHAR_NUM*`N_LEN-1:0]     buf_r;
    logic [`N*`N_LEN-1:0]               cur_max_r;
    logic [`N*`CHAR_LEN-1:0]            cur_idx_r;
    logic [`N*`N_LEN-1:0]               nxt_max_s;
    logic [`N*`CHAR_LEN-1:0]            nxt_idx_s;
    logic [`N_LEN-1:0]                  new_val_s [`N];
    logic                               load_s;
    logic                               step_s;
    logic                               last_s;
    logic                               finish_s;
    logic                               valid_nxt_s;

    // Keep the element select inside the row; with a single column the
    // counter already sits past the end when the first SCAN edge arrives.
    always_comb begin
        col_sel_s = '0;
        if (col_r < (`CHAR_LEN+1)'(`CHAR_NUM)) begin
            col_sel_s = col_r;
        end else begin
            col_sel_s = '0;
        end
    end

    genvar r;
    generate
        for (r = 0; r < `N; r++) begin : g_row
            assign new_val_s[r] = buf_r[(r * `CHAR_NUM + 32'(col_sel_s)) * `N_LEN +: `N_LEN];

            max_cmp u_cmp (
                .cur_max (cur_max_r[r*`N_LEN +: `N_LEN]),
                .cur_idx (cur_idx_r[r*`CHAR_LEN +: `CHAR_LEN]),
                .new_val (new_val_s[r]),
                .col     (col_sel_s[`CHAR_LEN-1:0]),
                .nxt_max (nxt_max_s[r*`N_LEN +: `N_LEN]),
                .nxt_idx (nxt_idx_s[r*`CHAR_LEN +: `CHAR_LEN])
            );
        end
    endgenerate

    // Next-state and datapath control of the scan FSM.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        step_s      = 1'b0;
        valid_nxt_s = 1'b0;
        last_s      = (`CHAR_NUM == 1) || (col_r == (`CHAR_LEN+1)'(`CHAR_NUM - 1));
        finish_s    = 1'b0;
        case (state_r)
            MAX_ST_IDLE: begin
                if (run) begin
                    load_s      = 1'b1;
                    state_nxt_s = MAX_ST_SCAN;
                end else begin
                    state_nxt_s = MAX_ST_IDLE;
                end
            end
            MAX_ST_SCAN: begin
                if (!run) begin
                    state_nxt_s = MAX_ST_IDLE;
                end else if (last_s) begin
                    step_s      = 1'b1;
                    finish_s    = 1'b1;
                    valid_nxt_s = 1'b1;
                    state_nxt_s = MAX_ST_DONE;
                end else begin
                    step_s      = 1'b1;
                    state_nxt_s = MAX_ST_SCAN;
                end
            end
            MAX_ST_DONE: begin
                if (run) begin
                    valid_nxt_s = 1'b1;
                    state_nxt_s = MAX_ST_DONE;
                end else begin
                    state_nxt_s = MAX_ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = MAX_ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= MAX_ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Capture buffer, running max/argmax, column counter and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_r     <= '0;
            cur_max_r <= '0;
            cur_idx_r <= '0;
            col_r     <= '0;
            valid     <= 1'b0;
            q_max     <= '0;
            q_idx     <= '0;
        end else begin
            if (load_s) begin
                buf_r <= d;
                for (int i = 0; i < `N; i++) begin
                    cur_max_r[i*`N_LEN +: `N_LEN] <= d[elem_lsb(i, 0) +: `N_LEN];
                end
                cur_idx_r <= '0;
                col_r     <= (`CHAR_LEN+1)'(1);
            end else if (step_s) begin
                cur_max_r <= nxt_max_s;
                cur_idx_r <= nxt_idx_s;
                col_r     <= col_r + (`CHAR_LEN+1)'(1);
            end
            if (finish_s) begin
                q_max <= nxt_max_s;
                q_idx <= nxt_idx_s;
            end
            valid <= valid_nxt_s;
        end
    end

endmodule

// File: tb/tb_max_layer.sv
// Directed self-checking bench for max_layer (N=2, CHAR_NUM=10, N_LEN=16).
module tb_max_layer;
    import max_layer_pkg::*;

    localparam int DW = ROWS * COLS * VW;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              run;
    logic [DW-1:0]     d;
    logic              valid;
    logic [ROWS*VW-1:0] q_max;
    logic [ROWS*IW-1:0] q_idx;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    max_layer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .d     (d),
        .valid (valid),
        .q_max (q_max),
        .q_idx (q_idx)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input int r, input int c, input logic [15:0] v);
        d[(r*COLS + c)*VW +: VW] = v;
    endtask

    task automatic fill(input int r, input logic [15:0] v);
        for (int c = 0; c < COLS; c++) put(r, c, v);
    endtask

    function automatic logic [15:0] qm(input int r);
        return q_max[r*VW +: VW];
    endfunction

    function automatic logic [15:0] qi(input int r);
        return 16'(q_idx[r*IW +: IW]);
    endfunction

    // Start a scan, scramble d after capture, check valid stays low until
    // exactly CHAR_NUM-1 edges after the start edge.
    task automatic do_scan(input string tag);
        run = 1'b1;
        tick();
        d = ~d;
        for (int i = 0; i < COLS - 1; i++) begin
            check({tag, "_busy"}, 16'(valid), 16'd0);
            tick();
        end
        check({tag, "_valid"}, 16'(valid), 16'd1);
    endtask

    task automatic expect_q(input string tag, input logic [15:0] m0, input logic [15:0] i0,
                            input logic [15:0] m1, input logic [15:0] i1);
        check({tag, "_max0"}, qm(0), m0);
        check({tag, "_idx0"}, qi(0), i0);
        check({tag, "_max1"}, qm(1), m1);
        check({tag, "_idx1"}, qi(1), i1);
    endtask

    initial begin
        rst_n = 1'b0;
        run   = 1'b0;
        d     = '0;
        tick();
        tick();
        check("rst_valid", 16'(valid), 16'd0);
        expect_q("rst", 16'h0000, 16'd0, 16'h0000, 16'd0);
        rst_n = 1'b1;
        tick();

        // Ramp in row 0, constant 5 in row 1.
        for (int c = 0; c < COLS; c++) put(0, c, 16'(c));
        fill(1, 16'd5);
        do_scan("ramp");
        expect_q("ramp", 16'd9, 16'd9, 16'd5, 16'd0);

        // Hold run: valid and outputs stay stable.
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold_valid", 16'(valid), 16'd1);
            check("hold_max0", qm(0), 16'd9);
            check("hold_idx1", qi(1), 16'd0);
        end
        run = 1'b0;
        tick();
        check("release_valid", 16'(valid), 16'd0);
        expect_q("release", 16'd9, 16'd9, 16'd5, 16'd0);

        // Signed compare in row 0, duplicate maxima in row 1.
        fill(0, 16'h8000);
        put(0, 3, 16'hFFFF);
        fill(1, 16'd1);
        put(1, 2, 16'd7);
        put(1, 9, 16'd7);
        do_scan("sgn");
        expect_q("sgn", 16'hFFFF, 16'd3, 16'd7, 16'd2);
        run = 1'b0;
        tick();

        // Abort at col 4: no valid, previous result kept.
        fill(0, 16'd100);
        fill(1, 16'd100);
        run = 1'b1;
        tick();
        tick();
        tick();
        tick();
        run = 1'b0;
        tick();
        check("abort_valid", 16'(valid), 16'd0);
        expect_q("abort", 16'hFFFF, 16'd3, 16'd7, 16'd2);
        for (int i = 0; i < COLS; i++) tick();
        check("abort_idle_valid", 16'(valid), 16'd0);

        // Restart with new data: result only reflects the new d.
        for (int c = 0; c < COLS; c++) put(0, c, 16'(-(c + 2)));
        fill(1, 16'd0);
        put(1, 5, 16'd3);
        do_scan("restart");
        expect_q("restart", 16'hFFFE, 16'd0, 16'd3, 16'd5);
        run = 1'b0;
        tick();

        // Reset mid-scan clears outputs and returns to IDLE.
        fill(0, 16'd40);
        fill(1, 16'd41);
        run = 1'b1;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("midrst_valid", 16'(valid), 16'd0);
        expect_q("midrst", 16'h0000, 16'd0, 16'h0000, 16'd0);
        run   = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        check("midrst_idle_valid", 16'(valid), 16'd0);
        expect_q("midrst_idle", 16'h0000, 16'd0, 16'h0000, 16'd0);

        // Two back-to-back batch slots.
        fill(0, 16'd2);
        put(0, 7, 16'd50);
        fill(1, 16'hFFFB);
        do_scan("slot0");
        expect_q("slot0", 16'd50, 16'd7, 16'hFFFB, 16'd0);
        run = 1'b0;
        tick();
        for (int c = 0; c < COLS; c++) put(0, c, 16'(9 - c));
        fill(1, 16'd0);
        put(1, 9, 16'd1);
        do_scan("slot1");
        expect_q("slot1", 16'd9, 16'd0, 16'd1, 16'd9);
        run = 1'b0;
        tick();
        check("slot1_release", 16'(valid), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
